// File: rtl/gray8_pkg.sv
// Shared constants, pixel type and kernel helpers for the 8-bit grayscale blur stage.
package gray8_pkg;
  localparam int IMG_WIDTH_DEF  = 320;
  localparam int IMG_HEIGHT_DEF = 240;
  localparam int KERNEL_SHIFT   = 4;
  localparam int ROUND_BIAS     = 8;

  typedef logic [7:0] pixel_t;

  // One kernel row [1 2 1]; max 1020, fits 12 bits with headroom for the full sum.
  function automatic logic [11:0] row121(input pixel_t a, input pixel_t b, input pixel_t c);
    return 12'(a) + {3'b000, b, 1'b0} + 12'(c);
  endfunction

  // Sum tops out at 4080, so sum+8 stays inside 12 bits and the result inside 8.
  function automatic pixel_t kround(input logic [11:0] sum);
    return pixel_t'((sum + 12'(ROUND_BIAS)) >> KERNEL_SHIFT);
  endfunction
endpackage

// File: rtl/line_buffer_gray8.sv
// One raster line of pixels; synchronous read-before-write, separate read/write addresses.
module line_buffer_gray8
  import gray8_pkg::*;
#(
  parameter int DEPTH = IMG_WIDTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re_i,
  input  logic          clr_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  pixel_t        wdata_i,
  output pixel_t        rdata_o
);
  pixel_t mem [DEPTH];
  pixel_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; stored pixels survive reset.
  always_ff @(posedge clk) begin
    if (!rst_n)     rdata_q <= '0;
    else if (re_i)  rdata_q <= mem[raddr_i];
    else if (clr_i) rdata_q <= '0;
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/gaussian_3x3_gray8.sv
// 3x3 Gaussian [1 2 1;2 4 2;1 2 1]/16 on a raster gray8 stream, 2-cycle pipeline after accept.
// Define GAUSS_BYPASS_EN to add the bypass input (unfiltered centre, same timing).
module gaussian_3x3_gray8
  import gray8_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int COL_W      = 9,
  parameter int ROW_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       pixel_in,
  input  logic             vsync,
  input  logic             active_area,
`ifdef GAUSS_BYPASS_EN
  input  logic             bypass,
`endif
  output logic [7:0]       pixel_out,
  output logic             pixel_valid,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col
);
  localparam int LB_AW = $clog2(IMG_WIDTH);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  logic byp;
`ifdef GAUSS_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif

  logic             vsync_q, act_q, armed_q, done_q, done_d;
  logic [ROW_W-1:0] row_q, row_d, row_eff;
  logic [COL_W-1:0] col_q, col_d, col_eff;
  logic             vs_rise, accept, line_end, emit;

  assign vs_rise = vsync & ~vsync_q;
  assign accept  = enable & active_area & (vs_rise | (armed_q & ~done_q));
  assign row_eff = vs_rise ? '0 : row_q;
  assign col_eff = vs_rise ? '0 : col_q;
  // A short line (active_area drops before the last column) still advances the row.
  assign line_end = (accept & (col_eff == COL_LAST)) |
                    (act_q & ~active_area & (col_q != '0) & ~vs_rise & armed_q & ~done_q);
  assign emit = accept & (row_eff != '0) & (col_eff != '0);

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    done_d = done_q;
    if (vs_rise) begin
      row_d  = '0;
      col_d  = '0;
      done_d = 1'b0;
    end
    if (line_end) begin
      col_d = '0;
      if (row_eff == ROW_LAST) done_d = 1'b1;
      else                     row_d  = row_eff + ROW_W'(1);
    end else if (accept) begin
      col_d = col_eff + COL_W'(1);
    end
  end

  // vsync_q resets high so a vsync already high at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q <= 1'b1;
      act_q   <= 1'b0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      vsync_q <= vsync;
      act_q   <= active_area;
      if (vs_rise) armed_q <= 1'b1;
      done_q  <= done_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // lb1 holds row r-1; lb2 is filled from lb1's read one cycle later (row r-2).
  pixel_t           rd1, rd2, pix_q;
  logic             wr2_q;
  logic [LB_AW-1:0] wa2_q;

  line_buffer_gray8 #(.DEPTH(IMG_WIDTH), .AW(LB_AW)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .re_i(accept), .clr_i(vs_rise), .raddr_i(col_eff[LB_AW-1:0]),
    .we_i(accept), .waddr_i(col_eff[LB_AW-1:0]), .wdata_i(pixel_in), .rdata_o(rd1)
  );

  line_buffer_gray8 #(.DEPTH(IMG_WIDTH), .AW(LB_AW)) u_lb2 (
    .clk(clk), .rst_n(rst_n), .re_i(accept), .clr_i(vs_rise), .raddr_i(col_eff[LB_AW-1:0]),
    .we_i(wr2_q), .waddr_i(wa2_q), .wdata_i(rd1), .rdata_o(rd2)
  );

  // Window columns: col0 newest (live from line-buffer outputs), w1 centre, w2 oldest.
  // Row index 0 = row r, 1 = r-1, 2 = r-2.
  logic [2:0][7:0] w1_q, w2_q, col0;
  assign col0 = {rd2, rd1, pix_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w1_q  <= '0;
      w2_q  <= '0;
      pix_q <= '0;
      wr2_q <= 1'b0;
      wa2_q <= '0;
    end else begin
      wr2_q <= accept;
      if (accept) wa2_q <= col_eff[LB_AW-1:0];
      if (vs_rise) begin
        w1_q  <= '0;
        w2_q  <= '0;
        pix_q <= accept ? pixel_in : '0;
      end else if (accept) begin
        w2_q  <= w1_q;
        w1_q  <= col0;
        pix_q <= pixel_in;
      end
    end
  end

  logic [11:0] sum;
  assign sum = row121(w2_q[0], w1_q[0], col0[0]) +
               (row121(w2_q[1], w1_q[1], col0[1]) << 1) +
               row121(w2_q[2], w1_q[2], col0[2]);

  logic [2:0]       vld_pipe_q;
  logic             brd0_q, brd1_q;
  logic [ROW_W-1:0] orow0_q, orow1_q, orow2_q;
  logic [COL_W-1:0] ocol0_q, ocol1_q, ocol2_q;
  logic [11:0]      sum1_q;
  pixel_t           cen1_q, pout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      brd0_q     <= 1'b0;
      brd1_q     <= 1'b0;
      orow0_q    <= '0;
      orow1_q    <= '0;
      orow2_q    <= '0;
      ocol0_q    <= '0;
      ocol1_q    <= '0;
      ocol2_q    <= '0;
      sum1_q     <= '0;
      cen1_q     <= '0;
      pout_q     <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1:0], emit};
      if (accept) begin
        brd0_q  <= (row_eff == ROW_W'(1)) | (col_eff == COL_W'(1)) | byp;
        orow0_q <= row_eff - ROW_W'(1);
        ocol0_q <= col_eff - COL_W'(1);
      end
      sum1_q  <= sum;
      cen1_q  <= w1_q[1];
      brd1_q  <= brd0_q;
      orow1_q <= orow0_q;
      ocol1_q <= ocol0_q;
      if (vld_pipe_q[1]) begin
        pout_q  <= brd1_q ? cen1_q : kround(sum1_q);
        orow2_q <= orow1_q;
        ocol2_q <= ocol1_q;
      end
    end
  end

  assign pixel_out   = pout_q;
  assign pixel_valid = vld_pipe_q[2];
  assign out_row     = orow2_q;
  assign out_col     = ocol2_q;
endmodule

// File: tb/tb_gaussian_3x3_gray8.sv
// Bench for gaussian_3x3_gray8: per-cycle compare against a frame-array Gaussian model.
module tb_gaussian_3x3_gray8;
  localparam int W = 12, H = 8, CW = 9, RW = 8;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, vsync = 1'b0, active_area = 1'b0;
  logic [7:0] pixel_in = '0;
`ifdef GAUSS_BYPASS_EN
  logic bypass = 1'b0;
`endif
  logic [7:0]    pixel_out;
  logic          pixel_valid;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;

  always #5 clk = ~clk;

  gaussian_3x3_gray8 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(CW), .ROW_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pixel_in(pixel_in), .vsync(vsync),
    .active_area(active_area),
`ifdef GAUSS_BYPASS_EN
    .bypass(bypass),
`endif
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .out_row(out_row), .out_col(out_col)
  );

  int n_chk = 0, n_fail = 0, cyc = 0, gcnt = 0;
  int out_cnt = 0, t_acc = -100, t_out = 0;
  int img[H][W];
  int out_img[H][W];
  int ref_img[H][W];

  typedef struct {int due; int r; int c; int v;} exp_t;
  exp_t q[$];

  int  m_row = 0, m_col = 0;
  bit  m_armed = 0, m_done = 0, m_vs_prev = 1, m_act_prev = 0;

  function automatic int expect_px(int r, int c, bit bp);
    int s = 0;
    if (bp || r == 0 || c == 0) return img[r][c];
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += img[r+dr][c+dc] * (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
    return (s + 8) / 16;
  endfunction

  function automatic void next_line();
    m_col = 0;
    if (m_row == H - 1) m_done = 1;
    else m_row++;
  endfunction

  // Reference model: raster position and frame image from the input rules.
  always @(posedge clk) begin : model
    bit vr, acc, bp;
    int r, c;
    cyc++;
    if (!rst_n) begin
      m_armed = 0; m_done = 0; m_row = 0; m_col = 0; m_vs_prev = 1; m_act_prev = 0;
      q.delete();
    end else begin
      bp = 0;
`ifdef GAUSS_BYPASS_EN
      bp = bypass;
`endif
      vr = vsync && !m_vs_prev;
      if (vr) begin m_armed = 1; m_done = 0; m_row = 0; m_col = 0; end
      acc = enable && active_area && m_armed && !m_done;
      if (acc) begin
        r = m_row; c = m_col;
        img[r][c] = int'(pixel_in);
        if (r == 2 && c == 2) t_acc = cyc;
        if (r >= 1 && c >= 1) q.push_back('{cyc + 2, r - 1, c - 1, expect_px(r - 1, c - 1, bp)});
        if (c == W - 1) next_line();
        else m_col++;
      end else if (m_act_prev && !active_area && m_col != 0 && !m_done) begin
        next_line();
      end
      m_vs_prev = vsync; m_act_prev = active_area;
    end
  end

  always @(negedge clk) begin : compare
    if (pixel_valid) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL stream: unexpected output row %0d col %0d px %0d at cyc %0d",
                 out_row, out_col, pixel_out, cyc);
      end else begin
        if (q[0].due != cyc || int'(pixel_out) != q[0].v || int'(out_row) != q[0].r ||
            int'(out_col) != q[0].c) begin
          n_fail++;
          $display("FAIL stream: got r%0d c%0d px %0d cyc %0d, want r%0d c%0d px %0d cyc %0d",
                   out_row, out_col, pixel_out, cyc, q[0].r, q[0].c, q[0].v, q[0].due);
        end
        void'(q.pop_front());
      end
      if (out_row < RW'(H - 1) && out_col < CW'(W - 1)) out_img[out_row][out_col] = int'(pixel_out);
      if (out_row == 1 && out_col == 1) t_out = cyc;
      out_cnt++;
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      n_chk++; n_fail++;
      $display("FAIL stream: missing output r%0d c%0d px %0d due cyc %0d", q[0].r, q[0].c, q[0].v, q[0].due);
      void'(q.pop_front());
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_out();
    out_cnt = 0;
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) out_img[r][c] = -1;
  endtask

  function automatic int gen(int mode, int r, int c);
    case (mode)
      0: return 8'h80;
      1: return (r == 5 && c == 5) ? 255 : 0;
      2: return c;
      3: return int'($urandom_range(0, 255));
      default: return (r * 37 + c * 11 + r * c * 5) & 255;
    endcase
  endfunction

  task automatic drive_line(input int r, input int mode, input int gap, input int len);
    int c = 0;
    active_area = 1'b1;
    while (c < len) begin
      case (gap)
        1: enable = (gcnt % 3) != 2;
        2: enable = $urandom_range(0, 3) != 0;
        default: enable = 1'b1;
      endcase
      gcnt++;
      pixel_in = 8'(gen(mode, r, c));
      tick();
      if (enable) c++;
    end
    active_area = 1'b0; enable = 1'b0;
    tick(); tick();
  endtask

  task automatic start_frame();
    vsync = 1'b1; tick();
    vsync = 1'b0; tick();
  endtask

  task automatic frame(input int mode, input int gap, input int nlines, input int lastlen);
    clr_out();
    start_frame();
    for (int r = 0; r < nlines; r++) drive_line(r, mode, gap, (r == H - 1) ? lastlen : W);
    repeat (4) tick();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_px"}, int'(pixel_out), 0);
    chk({tag, "_valid"}, int'(pixel_valid), 0);
    chk({tag, "_row"}, int'(out_row), 0);
    chk({tag, "_col"}, int'(out_col), 0);
  endtask

  initial begin
    int diffs;
    repeat (3) tick();
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    tick();
    // a line before any vsync must be ignored
    clr_out();
    drive_line(0, 3, 0, W);
    chk("unarmed_count", out_cnt, 0);

    frame(0, 0, H, W);
    chk("flat_count", out_cnt, (W - 1) * (H - 1));
    chk("flat_px", out_img[3][4], 128);

    frame(1, 0, H, W);
    chk("imp_centre", out_img[5][5], 64);
    chk("imp_up", out_img[4][5], 32);
    chk("imp_right", out_img[5][6], 32);
    chk("imp_diag_ul", out_img[4][4], 16);
    chk("imp_diag_dr", out_img[6][6], 16);
    chk("imp_far", out_img[2][2], 0);

    frame(2, 0, H, W);
    chk("ramp_interior", out_img[3][4], 4);
    chk("ramp_interior_edge", out_img[2][10], 10);
    chk("ramp_border_row", out_img[0][7], 7);
    chk("ramp_border_col", out_img[4][0], 0);
    chk("latency", t_out - t_acc, 2);

    frame(4, 0, H, W);
    ref_img = out_img;
    frame(4, 1, H, W);
    diffs = 0;
    for (int r = 0; r < H - 1; r++)
      for (int c = 0; c < W - 1; c++) if (out_img[r][c] != ref_img[r][c]) diffs++;
    chk("gap_diffs", diffs, 0);
    chk("gap_count", out_cnt, (W - 1) * (H - 1));

    // reset in the middle of a line
    start_frame();
    for (int r = 0; r < 3; r++) drive_line(r, 3, 0, W);
    active_area = 1'b1; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin pixel_in = 8'($urandom_range(0, 255)); tick(); end
    rst_n = 1'b0; tick();
    chk_zero_outputs("midrst");
    rst_n = 1'b1;
    clr_out();
    repeat (6) tick();
    active_area = 1'b0; enable = 1'b0; tick();
    for (int r = 0; r < 3; r++) drive_line(r, 3, 0, W);
    repeat (4) tick();
    chk("no_out_after_reset", out_cnt, 0);

    frame(3, 2, H, W);
    chk("recover_count", out_cnt, (W - 1) * (H - 1));
    frame(3, 0, H + 2, W);
    chk("extra_lines_count", out_cnt, (W - 1) * (H - 1));
    frame(3, 0, H, 6);
    chk("short_last_count", out_cnt, (W - 1) * (H - 2) + 5);
    for (int k = 0; k < 3; k++) frame(3, 2, H, W);
    chk("random_count", out_cnt, (W - 1) * (H - 1));

`ifdef GAUSS_BYPASS_EN
    bypass = 1'b1;
    frame(1, 0, H, W);
    chk("byp_centre", out_img[5][5], 255);
    chk("byp_up", out_img[4][5], 0);
    chk("byp_diag", out_img[4][4], 0);
    bypass = 1'b0;
`endif

    repeat (4) tick();
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
